// File: rtl/screen_rand_gen_if.sv
// ---------------------------------------------------------------------------
// screen_rand_gen_if
//
// Groups the request/response signals between the game FSM (master) and the
// screen value generator (slave).
//
// Signals:
//   req          master -> slave  one-cycle request pulse
//   first_out    slave  -> master bottom screen 1 value
//   second_out   slave  -> master bottom screen 2 value
//   third_out    slave  -> master bottom screen 3 value
//   fourth_out   slave  -> master bottom screen 4 value
//   main_out     slave  -> master main screen value
//   screen_done  slave  -> master level, outputs hold a fresh stable set
//   busy         slave  -> master request in progress
//   fsm_state    slave  -> master generator FSM state, for observation
// ---------------------------------------------------------------------------
interface screen_rand_gen_if;
    logic       req;
    logic [1:0] first_out;
    logic [1:0] second_out;
    logic [1:0] third_out;
    logic [1:0] fourth_out;
    logic [1:0] main_out;
    logic       screen_done;
    logic       busy;
    logic [1:0] fsm_state;

    modport master (
        output req,
        input  first_out, second_out, third_out, fourth_out, main_out,
        input  screen_done, busy, fsm_state
    );

    modport slave (
        input  req,
        output first_out, second_out, third_out, fourth_out, main_out,
        output screen_done, busy, fsm_state
    );
endinterface

// File: rtl/screen_rand_gen.sv
// ---------------------------------------------------------------------------
// screen_rand_gen
//
// Pseudo-random screen value producer for the bomb-defuse game. A 16-bit
// Fibonacci LFSR (x^16+x^14+x^13+x^11+1) free-runs every cycle. A request
// burns SPIN_CYCLES cycles, then latches four bottom-screen values and one
// main-screen value from the LFSR and raises screen_done.
//
// Handshake: req is sampled on every rising edge but only acts in IDLE.
// On the edge that accepts req, screen_done falls and busy rises. When the
// new set is latched, screen_done rises and busy falls on the same edge;
// screen_done then stays high until the next accepted req. The five value
// outputs only change while screen_done is low.
//
// Parameters:
//   SEED         LFSR reset value (0 is replaced by 16'h0001)
//   SPIN_CYCLES  extra LFSR steps per request, 1..255
//
// Ports:
//   CLK   clock, rising edge
//   RST   asynchronous active-low reset
//   bus   screen_rand_gen_if.slave (req, five values, screen_done, busy,
//         fsm_state)
//
// Optional feature macro: SCREEN_UNIQUE_TARGET_EN
//   When defined, a FIX state follows LOAD: the bottom screen selected by
//   lfsr[11:10] (captured at LOAD) is forced to 2'b11 and every other bottom
//   screen equal to 2'b11 becomes 2'b10, so exactly one shows 2'b11.
// ---------------------------------------------------------------------------
module screen_rand_gen #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          SPIN_CYCLES = 8
) (
    input  logic              CLK,
    input  logic              RST,
    screen_rand_gen_if.slave  bus
);

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  SPIN_INIT = 8'(SPIN_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SPIN = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
`ifdef SCREEN_UNIQUE_TARGET_EN
    localparam logic [1:0] ST_FIX  = 2'd3;
`endif

    logic [1:0]       state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [7:0]       spin_cnt_q, spin_cnt_d;
    logic [3:0][1:0]  bot_q, bot_d;
    logic [1:0]       main_q, main_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef SCREEN_UNIQUE_TARGET_EN
    logic [1:0]       tgt_q, tgt_d;
`endif

    logic fb;
    assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        // The all-zero state is a lock-up state for an XOR LFSR; escape it.
        lfsr_d     = (lfsr_q == 16'h0000) ? 16'h0001 : {lfsr_q[14:0], fb};
        state_d    = state_q;
        spin_cnt_d = spin_cnt_q;
        bot_d      = bot_q;
        main_d     = main_q;
        done_d     = done_q;
        busy_d     = busy_q;
`ifdef SCREEN_UNIQUE_TARGET_EN
        tgt_d      = tgt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    state_d    = ST_SPIN;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    spin_cnt_d = SPIN_INIT;
                end
            end
            ST_SPIN: begin
                if (spin_cnt_q == 8'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    spin_cnt_d = spin_cnt_q - 8'd1;
                end
            end
            ST_LOAD: begin
                bot_d[0] = lfsr_q[1:0];
                bot_d[1] = lfsr_q[3:2];
                bot_d[2] = lfsr_q[5:4];
                bot_d[3] = lfsr_q[7:6];
                main_d   = lfsr_q[9:8];
`ifdef SCREEN_UNIQUE_TARGET_EN
                tgt_d    = lfsr_q[11:10];
                state_d  = ST_FIX;
`else
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
`endif
            end
`ifdef SCREEN_UNIQUE_TARGET_EN
            ST_FIX: begin
                for (int i = 0; i < 4; i++) begin
                    if (tgt_q == i[1:0]) begin
                        bot_d[i] = 2'b11;
                    end else if (bot_q[i] == 2'b11) begin
                        bot_d[i] = 2'b10;
                    end
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= SEED_EFF;
            spin_cnt_q <= 8'd0;
            bot_q      <= '0;
            main_q     <= 2'b00;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SCREEN_UNIQUE_TARGET_EN
            tgt_q      <= 2'b00;
`endif
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            spin_cnt_q <= spin_cnt_d;
            bot_q      <= bot_d;
            main_q     <= main_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
`ifdef SCREEN_UNIQUE_TARGET_EN
            tgt_q      <= tgt_d;
`endif
        end
    end

    assign bus.first_out   = bot_q[0];
    assign bus.second_out  = bot_q[1];
    assign bus.third_out   = bot_q[2];
    assign bus.fourth_out  = bot_q[3];
    assign bus.main_out    = main_q;
    assign bus.screen_done = done_q;
    assign bus.busy        = busy_q;
    assign bus.fsm_state   = state_q;

endmodule

// File: doc/screen_rand_gen.md
# screen_rand_gen

Pseudo-random screen-value producer for the bomb-defuse game. On a one-cycle request pulse from the game FSM, it advances a 16-bit LFSR, then latches four 2-bit bottom-screen values and one 2-bit main-screen value, and raises `screen_done`. It is the responder side of the `pulse` / `screen_done` handshake that the game FSM drives in its Wait/Wait2/Start states. Its outputs feed both the game FSM and the display drivers.

## Interface

Parameters:
- `SEED`, default 16'hACE1: LFSR value loaded at reset. A value of 0 is replaced by 16'h0001.
- `SPIN_CYCLES`, default 8: number of extra LFSR steps burned per request before values are latched. Legal range 1..255.

Ports:
- `CLK` input, 1 bit: single clock. All state updates on the rising edge.
- `RST` input, 1 bit: reset, asynchronous, active-low.
- `req` input, 1 bit: request pulse from the game FSM. Sampled on each rising edge.
- `first_out` output, 2 bits: bottom screen 1 value.
- `second_out` output, 2 bits: bottom screen 2 value.
- `third_out` output, 2 bits: bottom screen 3 value.
- `fourth_out` output, 2 bits: bottom screen 4 value.
- `main_out` output, 2 bits: main screen value.
- `screen_done` output, 1 bit: level signal. High means the five outputs hold a fresh, stable set.
- `busy` output, 1 bit: high while a request is in progress.

## Operation

LFSR:
- Fibonacci form: `fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]`, next value `{lfsr[14:0], fb}`. Polynomial x^16+x^14+x^13+x^11+1, maximal length.
- Free-runs every cycle in every state except reset.
- If the register ever reads 0, it reloads 16'h0001 on the next edge.

FSM states:
- IDLE: `busy`=0, `screen_done` holds its value. `req`=1 → SPIN; on the same edge, `screen_done`←0, `busy`←1, `spin_cnt`←SPIN_CYCLES-1.
- SPIN: `spin_cnt` decrements each cycle. When `spin_cnt`==0 → LOAD.
- LOAD: latch `first_out`=lfsr[1:0], `second_out`=lfsr[3:2], `third_out`=lfsr[5:4], `fourth_out`=lfsr[7:6], `main_out`=lfsr[9:8].
  - Without the macro: `screen_done`←1, `busy`←0, → IDLE.
  - With the macro: → FIX.
- FIX (macro only): apply the unique-target rule (see Configuration), then `screen_done`←1, `busy`←0, → IDLE.

Other rules:
- `req` is ignored in SPIN, LOAD and FIX. No queuing.
- `req` held high in IDLE starts a new request on every return to IDLE. The game FSM pulses `req` for exactly one cycle.
- Outputs change only on the LOAD/FIX edge. They are never partially updated while `screen_done`=1.

## Timing

- Reset values: all screen outputs 2'b00, `screen_done`=0, `busy`=0, lfsr=SEED (or 16'h0001 if SEED is 0), state IDLE.
- Latency from the edge that samples `req`=1 to `screen_done` high:
  - SPIN_CYCLES+1 edges without the macro.
  - SPIN_CYCLES+2 edges with the macro.
- `screen_done` is low from the edge after `req` is sampled. The game FSM enters Start one cycle after the pulse, so it can never accept stale values.
- `RST` asserted mid-request: immediate abort, all reset values apply, no done pulse afterwards.
- Minimum request-to-request spacing: latency+1 cycles.

## Configuration

- `SCREEN_UNIQUE_TARGET_EN`
  - Defined:
    - The FIX state exists.
    - Target index = lfsr[11:10] captured at LOAD (0=first … 3=fourth).
    - The target screen is forced to 2'b11.
    - Every other bottom screen equal to 2'b11 is changed to 2'b10.
    - Result: exactly one bottom screen shows 2'b11. `main_out` is untouched.
  - Undefined: no FIX state. Bottom values are raw LFSR bits, so zero or several screens may equal 2'b11.

## Test plan

- Reset, then idle for 20 cycles → all outputs 2'b00, `screen_done`=0, `busy`=0. Assert `RST`=0 mid-SPIN → outputs return to 00, `busy`=0 asynchronously, and no done follows.
- SEED=16'hACE1, SPIN_CYCLES=8, macro off: one-cycle `req` → `busy` high for 9 cycles, `screen_done` rises on the 9th edge. Outputs equal the bit slices of the reference-model LFSR value at that edge.
- Back-to-back: second `req` 3 cycles after the first → ignored (exactly one done). A third `req` after done → `screen_done` drops on the next edge and rises again 9 edges later.
- SEED=16'h0000 → LFSR starts at 16'h0001. The first request's outputs match a model seeded with 1.
- Macro on, 256 consecutive requests → latency 10 edges each. Every set has exactly one bottom screen = 2'b11, at the index given by model lfsr[11:10]. Non-target screens are never 2'b11.
- Macro on, model state with all of lfsr[7:0]=8'hFF at LOAD → only the target screen is 11, the other three are 2'b10.
